// File: rtl/ram_bw_pipe.sv
// ram_bw_pipe: a parametrised single-port SRAM model with per-byte write
// enables, a read-valid/ready handshake, an optional second output register,
// and a zero-scrub that runs after every reset.
//
// Ports:
//   CLK    in   1      clock, all state changes on the rising edge
//   RST    in   1      asynchronous active-high reset
//   EN     in   1      access request, only taken while READY=1
//   WE     in   BYTES  byte write enables, WE[i] writes Di[8i+7:8i]
//   A      in   AW     word address (AW = 8 + clog2(COLS))
//   Di     in   DW     write data (DW = 8*BYTES)
//   Do     out  DW     registered read data, zero in slots with no result
//   VALID  out  1      Do holds a read result this cycle
//   READY  out  1      block accepts requests
//
// Every accepted access returns a word, including accesses that write.
// Optional feature macro: RAM_BW_PIPE_WRFWD_EN
//   undefined : read-first, a writing access returns the old word
//   defined   : write-first, a writing access returns the merged word
module ram_bw_pipe #(
    parameter int COLS    = 4,
    parameter int BYTES   = 4,
    parameter int OUT_REG = 1,
    parameter int SCRUB   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic [BYTES-1:0]        WE,
    input  logic [8+$clog2(COLS)-1:0] A,
    input  logic [8*BYTES-1:0]      Di,
    output logic [8*BYTES-1:0]      Do,
    output logic                    VALID,
    output logic                    READY
);
    localparam int DEPTH = 256 * COLS;
    localparam int AW    = 8 + $clog2(COLS);
    localparam int DW    = 8 * BYTES;

    typedef enum logic [0:0] {
        SCRUB_ST = 1'b0,
        RUN_ST   = 1'b1
    } state_t;

    // Replace the bytes selected by we with the matching bytes of nw.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old,
                                                  input logic [DW-1:0] nw,
                                                  input logic [BYTES-1:0] we);
        logic [DW-1:0] res;
        res = old;
        for (int b = 0; b < BYTES; b++) begin
            if (we[b]) begin
                res[8*b +: 8] = nw[8*b +: 8];
            end else begin
                res[8*b +: 8] = old[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [DW-1:0] r_mem [DEPTH];

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          r_ready;
    logic          w_ready_nxt;
    logic          w_scrub_wr;
    logic          w_acc;
    logic [DW-1:0] w_old;
    logic [DW-1:0] w_merged;
    logic [DW-1:0] w_rd;
    logic          r_v1;
    logic [DW-1:0] r_d1;

    // r_ready mirrors RUN_ST, so it alone gates accesses.
    assign w_acc    = r_ready & EN;
    assign w_old    = r_mem[A];
    assign w_merged = merge_bytes(w_old, Di, WE);

`ifdef RAM_BW_PIPE_WRFWD_EN
    assign w_rd = w_merged;
`else
    assign w_rd = w_old;
`endif

    // Scrub/run next-state logic; READY rises on the edge that writes the last word.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = r_ready;
        w_scrub_wr  = 1'b0;
        case (r_state)
            SCRUB_ST: begin
                w_scrub_wr = 1'b1;
                if (r_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = RUN_ST;
                    w_cnt_nxt   = '0;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + AW'(1);
                    w_ready_nxt = 1'b0;
                end
            end
            RUN_ST: begin
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = (SCRUB != 0) ? SCRUB_ST : RUN_ST;
                w_cnt_nxt   = '0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // FSM state, scrub counter and READY register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= (SCRUB != 0) ? SCRUB_ST : RUN_ST;
            r_cnt   <= '0;
            r_ready <= (SCRUB != 0) ? 1'b0 : 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Storage array: scrub writes zero, accesses write the byte-merged word.
    always_ff @(posedge CLK) begin
        if (!RST && w_scrub_wr) begin
            r_mem[r_cnt] <= '0;
        end else if (!RST && w_acc && (WE != '0)) begin
            r_mem[A] <= w_merged;
        end
    end

    // Stage 1: capture the access result, zero the slot when nothing was accepted.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else if (w_acc) begin
            r_v1 <= 1'b1;
            r_d1 <= w_rd;
        end else begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          r_v2;
            logic [DW-1:0] r_d2;

            // Stage 2: plain retiming register, adds one cycle of latency.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    r_d2 <= r_d1;
                end
            end

            assign Do    = r_d2;
            assign VALID = r_v2;
        end else begin : g_no_out_reg
            assign Do    = r_d1;
            assign VALID = r_v1;
        end
    endgenerate

    assign READY = r_ready;
endmodule

// File: tb/tb_ram_bw_pipe.sv
module tb_ram_bw_pipe;
    localparam int LAT = 2;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic [3:0]  WE;
    logic [7:0]  A;
    logic [31:0] Di;
    logic [31:0] Do;
    logic        VALID;
    logic        READY;

    ram_bw_pipe #(.COLS(1), .BYTES(4), .OUT_REG(1), .SCRUB(1)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .WE(WE), .A(A), .Di(Di),
        .Do(Do), .VALID(VALID), .READY(READY)
    );

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [256];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc = cyc + 1;

    // Monitor: every VALID must match the next expected word on its due cycle.
    always @(negedge CLK) begin
        if (!RST) begin
            if (VALID) begin
                n_tests = n_tests + 1;
                if (sb.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_valid actual Do=%h, required no VALID (cycle %0d)", Do, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (Do !== mon_e.d || cyc != mon_e.due) begin
                        n_fail = n_fail + 1;
                        $display("FAIL read_data actual=%h@%0d required=%h@%0d", Do, cyc, mon_e.d, mon_e.due);
                    end
                end
            end else begin
                n_tests = n_tests + 1;
                if (Do !== 32'h0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL idle_zero actual Do=%h required=00000000 (cycle %0d)", Do, cyc);
                end
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    mon_e = sb.pop_front();
                    n_fail = n_fail + 1;
                    $display("FAIL missing_valid actual VALID=0 required VALID=1 data=%h at %0d", mon_e.d, mon_e.due);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests = n_tests + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One access slot; the model decides acceptance from READY as it stands before the edge.
    task automatic access(input logic en, input logic [3:0] we, input logic [7:0] a, input logic [31:0] di);
        logic [31:0] old_w;
        logic [31:0] new_w;
        exp_t        e;
        @(negedge CLK);
        EN = en; WE = we; A = a; Di = di;
        if (en && READY) begin
            old_w = ref_mem[a];
            new_w = old_w;
            for (int b = 0; b < 4; b++) begin
                if (we[b]) new_w[8*b +: 8] = di[8*b +: 8];
            end
`ifdef RAM_BW_PIPE_WRFWD_EN
            e.d = new_w;
`else
            e.d = old_w;
`endif
            e.due = cyc + LAT;
            sb.push_back(e);
            ref_mem[a] = new_w;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            EN = 1'b0; WE = 4'h0;
        end
    endtask

    // Count cycles from the current negedge until READY is seen high.
    task automatic count_scrub(input string name, input int required);
        int n;
        n = 0;
        while (READY !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n = n + 1;
        end
        check(name, 32'(n), 32'(required));
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; WE = 4'h0; A = 8'h00; Di = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        repeat (3) @(negedge CLK);
        check("reset_do", Do, 32'h0);
        check("reset_valid", {31'h0, VALID}, 32'h0);
        check("reset_ready", {31'h0, READY}, 32'h0);

        // Gated write attempt held for the whole scrub.
        EN = 1'b1; WE = 4'hF; A = 8'h33; Di = 32'hDEADBEEF;
        RST = 1'b0;
        count_scrub("scrub_cycles", 256);
        EN = 1'b0; WE = 4'h0;

        access(1'b1, 4'h0, 8'h00, 32'h0);
        access(1'b1, 4'h0, 8'hFF, 32'h0);
        access(1'b1, 4'h0, 8'h33, 32'h0);
        idle(2);

        // Byte writes.
        access(1'b1, 4'hF, 8'h10, 32'hAABBCCDD);
        access(1'b1, 4'h2, 8'h10, 32'h00001100);
        access(1'b1, 4'h0, 8'h10, 32'h0);
        idle(3);
        check("byte_write_model", ref_mem[8'h10], 32'hAABB11DD);

        // Same-edge read/write then follow-up read.
        access(1'b1, 4'hF, 8'h05, 32'h11111111);
        access(1'b1, 4'hF, 8'h05, 32'h22222222);
        access(1'b1, 4'h0, 8'h05, 32'h0);
        idle(1);

        // Throughput with idle slot.
        access(1'b1, 4'h0, 8'h10, 32'h0);
        access(1'b1, 4'h0, 8'h05, 32'h0);
        access(1'b1, 4'h0, 8'hFF, 32'h0);
        idle(1);
        access(1'b1, 4'h0, 8'h10, 32'h0);
        idle(3);

        // Randomised traffic, concentrated on a few addresses for hazards.
        for (int i = 0; i < 300; i++) begin
            access($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0,
                   ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255)),
                   $urandom);
        end
        idle(LAT + 2);
        check("drain_queue", 32'(sb.size()), 32'h0);

        // Reset with a read in flight: the read is dropped.
        access(1'b1, 4'h0, 8'h10, 32'h0);
        @(negedge CLK);
        EN = 1'b0;
        RST = 1'b1;
        sb.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        @(negedge CLK);
        check("inflight_drop_valid", {31'h0, VALID}, 32'h0);
        check("rst_run_ready", {31'h0, READY}, 32'h0);

        // Reset again 100 cycles into the scrub; full scrub must restart.
        RST = 1'b0;
        repeat (100) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        count_scrub("scrub_restart_cycles", 256);

        access(1'b1, 4'h0, 8'h10, 32'h0);
        access(1'b1, 4'h0, 8'h05, 32'h0);
        idle(LAT + 2);
        check("final_drain", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
